dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port Data_Memory between the CPU load/store path (port 0) and a DMA/program-loader port (port 1). It sits between the CPU datapath's DM_ADDR/DM_DATA/MemRead/MemWrite signals and the memory instance. It also produces a stall that holds the CPU's PC while a CPU access is outstanding. Requests are registered, served one at a time with round-robin priority, and each is completed with a one-cycle acknowledge.

## Interface
Parameters:
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req0_i / req1_i  in  1  request, level; held until the matching ack.
- we0_i / we1_i  in  1  1 = write, 0 = read; sampled with the request.
- addr0_i / addr1_i  in  ADDR_W  byte address.
- wdata0_i / wdata1_i  in  DATA_W  write data.
- ack0_o / ack1_o  out  1  one-cycle completion pulse.
- rdata0_o / rdata1_o  out  DATA_W  read data; valid while the ack is high, held afterwards.
- cpu_stall_o  out  1  equals req0_i & ~ack0_o.
- mem_addr_o  out  ADDR_W  to Data_Memory addr_i.
- mem_wdata_o  out  DATA_W  to Data_Memory data_i.
- mem_read_o / mem_write_o  out  1  to MemRead_i / MemWrite_i.
- mem_rdata_i  in  DATA_W  from Data_Memory data_o; combinational read.

## Operation
FSM states: IDLE, BUSY, RESP. Registers:
- state
- gnt (1 bit, the port being served)
- last_gnt (1 bit, the port served most recently)
- lat_addr, lat_wdata, lat_we
- rdata0, rdata1

IDLE:
- No request: stay in IDLE.
- One request: grant that port.
- Both requests: grant ~last_gnt (round-robin).
- On a grant: latch addr/wdata/we of the granted port, set gnt, go to BUSY.

BUSY:
- mem_addr_o = lat_addr and mem_wdata_o = lat_wdata.
- mem_read_o = ~lat_we and mem_write_o = lat_we.
- Writes commit at the BUSY→RESP edge.
- For a read, mem_rdata_i is captured into rdata[gnt] at the same edge. For a write, rdata[gnt] is unchanged.
- last_gnt ← gnt. Go to RESP.

RESP:
- ack[gnt]_o = 1 for this cycle only.
- Requests are ignored. Go to IDLE.

Outside BUSY:
- mem_read_o = mem_write_o = 0.
- mem_addr_o and mem_wdata_o hold their last values (registered, not glitching).

Boundary behaviour:
- Requester drops req before its ack (protocol violation): the latched access still completes and the ack still pulses.
- New request arriving during BUSY/RESP: waits; it is arbitrated in the next IDLE cycle.
- Same port re-requests immediately while the other port is waiting: the other port wins, because last_gnt points at the re-requesting port.
- Address and data are not checked for alignment or range; they are passed through unchanged.

Reset (rst_i high, async):
- state = IDLE, gnt = 0, last_gnt = 1, so port 0 wins the first tie.
- lat_* = 0, rdata0/1 = 0.
- All acks and mem_read/mem_write = 0.
- mem_addr_o and mem_wdata_o = 0.
- Reset during BUSY aborts the access with no memory write. mem_write_o drops immediately, combinationally from state.
- Reset during RESP suppresses the ack.

## Timing
- Edge 0→1: req sampled in IDLE. Edge 1→2: write commits / read captured. Cycle 2: ack.
- Acked access = 3 cycles: request seen in IDLE at cycle N, memory driven in N+1, ack in N+2.
- Earliest next grant: cycle N+3, so peak throughput is 1 access per 3 cycles.
- Worst-case latency with the other port contending: 6 cycles from req to ack.
- cpu_stall_o is combinational: high from the cycle req0_i rises through the cycle before ack0_o, and low in the ack cycle.
- rdataX_o is registered and stable from the ack cycle until the next read completes on that port.

## Test plan
- Reset values: hold rst_i for 2 cycles → all outputs 0, state IDLE. Then assert req0 and req1 together → port 0 is acked first.
- Single write then read, port 0: write 0xDEADBEEF to 0x10, then read 0x10.
  - Write: ack0 exactly 2 cycles after the req is sampled; mem_write_o high for exactly 1 cycle.
  - Read: rdata0_o = 0xDEADBEEF with ack0; cpu_stall_o high for 2 cycles per access.
- Contention: both ports hold requests continuously for 4 accesses each → grants alternate 0,1,0,1…, each ack spaced 3 cycles apart, no port served twice in a row.
- Port isolation: port 1 reads 0x20 (0x12345678) while port 0 writes 0x24 → rdata0_o unchanged by port 1's read; rdata1_o = 0x12345678.
- Reset mid-BUSY: assert rst_i during the BUSY cycle of a write of 0xAAAA5555 to 0x30 → no ack, mem_write_o low immediately. A subsequent read of 0x30 returns the old value.
- Early req drop: port 1 deasserts req1 in the BUSY cycle → ack1 still pulses once. A pending req0 is granted in the next IDLE cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port Data_Memory between the CPU load/store path (port 0)
// and a DMA / program-loader port (port 1). Requests are registered and served
// one at a time with round-robin priority on ties. Each access takes three
// cycles: IDLE (request sampled), BUSY (memory driven), RESP (one-cycle ack).
// The CPU is stalled while its own request is outstanding.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   reqN_i / weN_i            level request held until ackN_o, 1 = write
//   addrN_i / wdataN_i        byte address / write data of port N
//   ackN_o                    one-cycle completion pulse for port N
//   rdataN_o                  read data of port N, valid with ack, held after
//   cpu_stall_o               req0_i & ~ack0_o (combinational)
//   mem_addr_o / mem_wdata_o  registered address / data to the memory
//   mem_read_o / mem_write_o  memory strobes, high only in BUSY
//   mem_rdata_i               combinational read data from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic              gnt_q,       gnt_d;
  logic              last_gnt_q,  last_gnt_d;
  logic [ADDR_W-1:0] lat_addr_q,  lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic              lat_we_q,    lat_we_d;
  logic [DATA_W-1:0] rdata0_q,    rdata0_d;
  logic [DATA_W-1:0] rdata1_q,    rdata1_d;
  logic              sel;

  // NOTE: every register, including the read-data holding registers, has a
  // reset value so outputs are defined from the first cycle after reset.
  // last_gnt resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_we_q    <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the values of
      // the previous cycle regardless of statement order.
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_we_q    <= lat_we_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  always_comb begin
    // NOTE: all next-state values default to hold before the case statement,
    // so no path through the logic can infer a latch.
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_we_d    = lat_we_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    sel         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          // Single requester wins outright; on a tie the port not served
          // most recently wins.
          sel         = (req0_i && req1_i) ? ~last_gnt_q : req1_i;
          gnt_d       = sel;
          lat_addr_d  = sel ? addr1_i  : addr0_i;
          lat_wdata_d = sel ? wdata1_i : wdata0_i;
          lat_we_d    = sel ? we1_i    : we0_i;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // The memory write itself happens inside Data_Memory on this edge;
        // reads capture its combinational output here.
        if (!lat_we_q) begin
          if (gnt_q) rdata1_d = mem_rdata_i;
          else       rdata0_d = mem_rdata_i;
        end
        last_gnt_d = gnt_q;
        state_d    = RESP;
      end
      RESP: begin
        // Requests are ignored here; anything pending is arbitrated in IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // during BUSY removes mem_write_o before the next edge can commit a write.
  assign mem_read_o  = (state_q == BUSY) && !lat_we_q;
  assign mem_write_o = (state_q == BUSY) &&  lat_we_q;
  assign mem_addr_o  = lat_addr_q;
  assign mem_wdata_o = lat_wdata_q;

  assign ack0_o      = (state_q == RESP) && !gnt_q;
  assign ack1_o      = (state_q == RESP) &&  gnt_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign cpu_stall_o = req0_i && !ack0_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a small word-addressed memory model.
// Stimulus pushes the expected acknowledge (port, read data) into a queue in
// the hand-derived service order; a monitor pops and compares on every ack.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, ack1, cpu_stall, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  typedef struct packed {
    logic        port;
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ack_cyc[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data_Memory stand-in: write on the clock edge, combinational read.
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_i      (req0),
    .we0_i       (we0),
    .addr0_i     (addr0),
    .wdata0_i    (wdata0),
    .req1_i      (req1),
    .we1_i       (we1),
    .addr1_i     (addr1),
    .wdata1_i    (wdata1),
    .ack0_o      (ack0),
    .ack1_o      (ack1),
    .rdata0_o    (rdata0),
    .rdata1_o    (rdata1),
    .cpu_stall_o (cpu_stall),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_rdata_i (mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_ack(input logic p, input logic rd, input logic [31:0] d);
    exp_t e;
    e.port    = p;
    e.is_read = rd;
    e.data    = d;
    sb.push_back(e);
  endfunction

  // Monitor: every ack pops one expectation.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      ack_cyc.push_back(cyc);
      check("ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port", {31'b0, ack1}, {31'b0, mon_e.port});
        if (mon_e.is_read)
          check("rdata", mon_e.port ? rdata1 : rdata0, mon_e.data);
      end
    end
  end

  // One access on port p. Called right after a posedge (+1); returns right
  // after the posedge following the ack, with the request dropped, so an
  // immediately following call re-requests with no gap.
  task automatic access(input logic p, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input bit drop,
                        output int lat, output int stall_n, output int wr_n);
    bit got;
    got     = 1'b0;
    lat     = -1;
    stall_n = 0;
    wr_n    = 0;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cpu_stall) stall_n++;
      if (mem_write) wr_n++;
      if (p ? ack1 : ack0) begin
        got = 1'b1;
        lat = i;
      end else if (drop && i == 0) begin
        @(posedge clk); #1;
        if (p) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    check($sformatf("ack_seen_p%0d", p), {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    int lat_a, st_a, wr_a, lat_b, st_b, wr_b;

    // ---- reset values ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_acks",   {30'b0, ack1, ack0}, 32'd0);
    check("rst_strobe", {30'b0, mem_write, mem_read}, 32'd0);
    check("rst_stall",  {31'b0, cpu_stall}, 32'd0);
    check("rst_addr",   mem_addr, 32'd0);
    check("rst_wdata",  mem_wdata, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- first tie goes to port 0 ----
    expect_ack(1'b0, 1'b0, '0);
    expect_ack(1'b1, 1'b0, '0);
    @(posedge clk); #1;
    fork
      access(1'b0, 1'b1, 32'h40, 32'h1111_1111, 1'b0, lat_a, st_a, wr_a);
      access(1'b1, 1'b1, 32'h44, 32'h2222_2222, 1'b0, lat_b, st_b, wr_b);
    join
    check("tie_p0_lat", lat_a, 32'd2);
    check("tie_p1_lat", lat_b, 32'd5);

    // ---- port 0 write then read ----
    expect_ack(1'b0, 1'b0, '0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat_a, st_a, wr_a);
    check("wr_lat",      lat_a, 32'd2);
    check("wr_strobe_n", wr_a,  32'd1);
    expect_ack(1'b0, 1'b1, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat_a, st_a, wr_a);
    check("rd_lat",     lat_a, 32'd2);
    check("rd_stall_n", st_a,  32'd2);

    // ---- contention: last served was port 0, so port 1 leads ----
    for (int i = 0; i < 4; i++) begin
      expect_ack(1'b1, 1'b1, (i % 2 == 0) ? 32'h2222_2222 : 32'hDEAD_BEEF);
      expect_ack(1'b0, 1'b0, '0);
    end
    ack_cyc.delete();
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 4; i++)
        access(1'b0, 1'b1, 32'h50 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, lat_a, st_a, wr_a);
      for (int j = 0; j < 4; j++)
        access(1'b1, 1'b0, (j % 2 == 0) ? 32'h44 : 32'h10, 32'h0, 1'b0, lat_b, st_b, wr_b);
    join
    check("cont_ack_count", ack_cyc.size(), 32'd8);
    for (int k = 1; k < ack_cyc.size(); k++)
      check($sformatf("cont_spacing_%0d", k), ack_cyc[k] - ack_cyc[k-1], 32'd3);

    // ---- port isolation ----
    expect_ack(1'b1, 1'b0, '0);
    @(posedge clk); #1;
    access(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, lat_b, st_b, wr_b);
    // Port 1 was served last, so port 0 wins this tie.
    expect_ack(1'b0, 1'b0, '0);
    expect_ack(1'b1, 1'b1, 32'h1234_5678);
    fork
      access(1'b0, 1'b1, 32'h24, 32'h5A5A_5A5A, 1'b0, lat_a, st_a, wr_a);
      access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat_b, st_b, wr_b);
    join
    check("iso_rdata0", rdata0, 32'hDEAD_BEEF);
    check("iso_rdata1", rdata1, 32'h1234_5678);

    // ---- reset in the BUSY cycle of a write ----
    expect_ack(1'b0, 1'b0, '0);
    access(1'b0, 1'b1, 32'h30, 32'h0BAD_0BAD, 1'b0, lat_a, st_a, wr_a);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hAAAA_5555;
    @(posedge clk); #1;
    check("busy_write_hi", {31'b0, mem_write}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_write_drop", {31'b0, mem_write}, 32'd0);
    req0 = 1'b0; we0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata0_clr", rdata0, 32'd0);
    expect_ack(1'b0, 1'b1, 32'h0BAD_0BAD);
    access(1'b0, 1'b0, 32'h30, 32'h0, 1'b0, lat_a, st_a, wr_a);

    // ---- port 1 drops its request in BUSY; port 0 arrives meanwhile ----
    expect_ack(1'b1, 1'b1, 32'h2222_2222);
    expect_ack(1'b0, 1'b1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    fork
      access(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, lat_b, st_b, wr_b);
      begin
        @(posedge clk); #1;
        access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat_a, st_a, wr_a);
      end
    join
    check("drop_p1_lat", lat_b, 32'd2);
    check("drop_p0_lat", lat_a, 32'd4);

    // ---- drain ----
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("sb_drain", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
